// File: rtl/card_draw_ctrl.sv
// Single-card sprite overlay: per-pixel hit test against a frame-latched card position,
// two-stage colour pipeline, and host sprite-RAM writes accepted only during vertical blanking.
module card_draw_ctrl #(
  parameter int unsigned CARD_W   = 16,
  parameter int unsigned CARD_H   = 32,
  parameter logic [2:0]  BG_COLOR = 3'b010
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vblank,
  input  logic       pix_valid,
  input  logic [7:0] pix_x,
  input  logic [7:0] pix_y,
  input  logic [7:0] card_x,
  input  logic [7:0] card_y,
  input  logic       host_req,
  input  logic [8:0] host_addr,
  input  logic [2:0] host_data,
  output logic       host_ack,
  output logic       ram_we,
  output logic       ram_re,
  output logic [8:0] ram_waddr,
  output logic [8:0] ram_raddr,
  output logic [2:0] ram_din,
  input  logic [2:0] ram_dout,
  output logic [2:0] pix_color,
  output logic       pix_out_valid
);

  localparam int unsigned XB = $clog2(CARD_W);
  localparam int unsigned YB = $clog2(CARD_H);
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 3;
  localparam int unsigned PW = 8;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_BLANK  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   sx_q, sx_d;
  logic [PW-1:0]   sy_q, sy_d;
  logic            host_ack_q, host_ack_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_waddr_q, ram_waddr_d;
  logic [CW-1:0]   ram_din_q, ram_din_d;
  logic            s0_valid_q, s0_valid_d;
  logic            s0_hit_q, s0_hit_d;
  logic [CW-1:0]   pix_color_q, pix_color_d;
  logic            pix_out_valid_q, pix_out_valid_d;

  logic [AW-1:0]   dx_c, dy_c;
  logic            hit_c;
  logic            rd_c;
  logic [AW-1:0]   raddr_c;

  // Hit test against the shadow position; 9-bit difference so off-left/top pixels go negative.
  always_comb begin
    dx_c    = {1'b0, pix_x} - {1'b0, sx_q};
    dy_c    = {1'b0, pix_y} - {1'b0, sy_q};
    hit_c   = !dx_c[8] && (dx_c < AW'(CARD_W)) && !dy_c[8] && (dy_c < AW'(CARD_H));
    raddr_c = AW'({dy_c[YB-1:0], dx_c[XB-1:0]});
    // A write completing in the first ACTIVE cycle owns the RAM port that cycle.
    rd_c    = pix_valid && hit_c && (state_q == ST_ACTIVE) && !ram_we_q;
  end

  always_comb begin
    state_d         = vblank ? ST_BLANK : ST_ACTIVE;
    sx_d            = sx_q;
    sy_d            = sy_q;
    host_ack_d      = 1'b0;
    ram_we_d        = 1'b0;
    ram_waddr_d     = ram_waddr_q;
    ram_din_d       = ram_din_q;
    s0_valid_d      = pix_valid;
    s0_hit_d        = rd_c;
    pix_out_valid_d = s0_valid_q;
    pix_color_d     = (s0_hit_q && (ram_dout != 3'b000)) ? ram_dout : BG_COLOR;

    if ((state_q == ST_BLANK) && !vblank) begin
      sx_d = card_x;
      sy_d = card_y;
    end

    // Previous-cycle ack blocks re-acceptance, giving one write per two cycles.
    if ((state_q == ST_BLANK) && host_req && !host_ack_q) begin
      host_ack_d  = 1'b1;
      ram_we_d    = 1'b1;
      ram_waddr_d = host_addr;
      ram_din_d   = host_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_ACTIVE;
      sx_q            <= '0;
      sy_q            <= '0;
      host_ack_q      <= 1'b0;
      ram_we_q        <= 1'b0;
      ram_waddr_q     <= '0;
      ram_din_q       <= '0;
      s0_valid_q      <= 1'b0;
      s0_hit_q        <= 1'b0;
      pix_color_q     <= '0;
      pix_out_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      sx_q            <= sx_d;
      sy_q            <= sy_d;
      host_ack_q      <= host_ack_d;
      ram_we_q        <= ram_we_d;
      ram_waddr_q     <= ram_waddr_d;
      ram_din_q       <= ram_din_d;
      s0_valid_q      <= s0_valid_d;
      s0_hit_q        <= s0_hit_d;
      pix_color_q     <= pix_color_d;
      pix_out_valid_q <= pix_out_valid_d;
    end
  end

  // Read port is combinational so RAM data lands in stage 0; reset forces it idle at once.
  assign ram_re        = rd_c & reset_n;
  assign ram_raddr     = reset_n ? raddr_c : '0;
  assign host_ack      = host_ack_q;
  assign ram_we        = ram_we_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_din       = ram_din_q;
  assign pix_color     = pix_color_q;
  assign pix_out_valid = pix_out_valid_q;

endmodule

// File: doc/card_draw_ctrl.md
CARD_DRAW_CTRL -- requirements
Module: card_draw_ctrl

Interface
REQ-001 Parameter CARD_W, default 16, card sprite width in pixels (power of two).
REQ-002 Parameter CARD_H, default 32, card sprite height in pixels; CARD_W*CARD_H SHALL equal 512 (card RAM depth).
REQ-003 Parameter BG_COLOR, default 3'b010, 3-bit colour output where no opaque card pixel is drawn.
REQ-004 clock  in  1  single system clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 vblank  in  1  high during vertical blanking.
REQ-007 pix_valid  in  1  pix_x/pix_y hold an active-display pixel this cycle.
REQ-008 pix_x, pix_y  in  8 each  current pixel coordinate (256x240 screen).
REQ-009 card_x, card_y  in  8 each  requested card top-left position.
REQ-010 host_req  in  1  host requests one sprite RAM write.
REQ-011 host_addr  in  9, host_data  in  3  write address and colour.
REQ-012 host_ack  out  1  one-cycle pulse: write issued.
REQ-013 ram_we, ram_re  out  1 each; ram_waddr, ram_raddr  out  9 each; ram_din  out  3  card RAM control.
REQ-014 ram_dout  in  3  card RAM read data, valid one clock after the read address is presented.
REQ-015 pix_color  out  3, pix_out_valid  out  1  rendered pixel and its qualifier.

Function
REQ-016 FSM states ACTIVE and BLANK; ACTIVE->BLANK when vblank=1, BLANK->ACTIVE when vblank=0, evaluated every cycle.
REQ-017 On the BLANK->ACTIVE transition, card_x/card_y SHALL be latched into shadow registers; rendering uses only the shadow values, so mid-frame position changes cannot tear.
REQ-018 Hit test: dx = {1'b0,pix_x} - {1'b0,sx}, dy = {1'b0,pix_y} - {1'b0,sy} (9-bit); hit when dx[8]=0, dx<CARD_W, dy[8]=0, dy<CARD_H; no wrap-around (card near x=255 SHALL be clipped, not wrapped).
REQ-019 Read address = dy*CARD_W + dx (i.e. {dy[4:0],dx[3:0]} at defaults); ram_re = pix_valid & hit & (state==ACTIVE).
REQ-020 Pipeline latency exactly 2 cycles: stage 0 registers hit/pix_valid alongside the RAM read; stage 1 registers pix_color and pix_out_valid = pix_valid delayed 2 cycles.
REQ-021 pix_color = ram_dout if delayed hit=1 and ram_dout!=3'b000; otherwise BG_COLOR (3'b000 is transparent).
REQ-022 Host writes are accepted only in BLANK: when state==BLANK, host_req=1 and host_ack=0, the next cycle drives ram_we=1, ram_waddr=host_addr, ram_din=host_data, host_ack=1 (registered).
REQ-023 Maximum write rate one per two cycles; host_req held high after host_ack is a new request.
REQ-024 host_req in ACTIVE is stalled (no ack, ram_we=0) until BLANK; host SHALL hold addr/data stable while waiting.
REQ-025 A write registered in the last BLANK cycle completes in the following cycle even if state is now ACTIVE; no further acks issue.
REQ-026 ram_we and ram_re never assert in the same cycle, so read-during-write hazards cannot occur.
REQ-027 pix_valid in BLANK yields pix_out_valid=1 with pix_color=BG_COLOR and ram_re=0.

Reset
REQ-028 reset_n=0 SHALL immediately force: state=ACTIVE, shadow position 0,0, host_ack=0, ram_we=0, ram_re=0, ram_waddr=0, ram_raddr=0, ram_din=0, pix_color=0, pix_out_valid=0, pipeline valids cleared.
REQ-029 Reset mid-write SHALL abort it: no ack and no ram_we after reset_n deasserts until a fresh request in BLANK.

Verification
REQ-030 Position latch: card_x=40, card_y=100 set in BLANK, vblank falls; pixel (45,103) -> ram_raddr=3*16+5=53, pix_color=RAM[53] two cycles later.
REQ-031 Clipping: shadow x=250, pixel (2,y in range) -> no hit, ram_re=0, pix_color=3'b010; pixel (255,...) -> ram_raddr low nibble 5.
REQ-032 Transparency: RAM[0]=3'b000, RAM[1]=3'b101, pixels at dx=0,1 -> pix_color 3'b010 then 3'b101.
REQ-033 Host stall: host_req=1 (addr 9'h1FF, data 3'b111) during ACTIVE for 100 cycles -> no ack; vblank rises -> ack one cycle after BLANK entry, RAM[511]=3'b111.
REQ-034 Back-to-back: host_req held high 10 cycles in BLANK -> exactly 5 acks and 5 ram_we pulses.
REQ-035 Async reset: reset_n low mid-write and mid-pipeline, no clock edge -> all outputs 0 at once; after release no stale ack or pix_out_valid.
